// File: rtl/alu_md_pkg.sv
// Shared decode constants and types for the iterative RV M-extension unit.
// The op enum mirrors funct3 so a decoded op can be cast straight from the instruction.
package alu_md_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  function automatic logic op_is_div(md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration over the 2*XLEN partial state: shift-add for multiply,
// restoring trial-subtract for divide. Upper half is the accumulator / remainder.
module md_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;
  logic          div_ge;

  // The remainder stays below the divisor, so the top bit of the difference is a clean borrow flag
  always_comb begin
    mul_sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    div_shift = acc_in[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, operand};
    div_ge    = ~div_diff[XLEN];
    if (is_div) begin
      acc_out = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_in[XLEN-2:0], div_ge};
    end else begin
      acc_out = {mul_sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_md.sv
// Iterative multiply/divide unit: magnitudes are iterated one bit per cycle in md_step,
// then signs are restored in a final cycle before the result is presented.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [31:0]     inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   STEPS   = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state;
  md_op_t            op;
  md_op_t            dec_op;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] step_out;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   special_val;
  logic [XLEN-1:0]   dec_special_val;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_val;
  logic              neg_res;
  logic              neg_rem;
  logic              special;
  logic              dec_special;
  logic              is_m;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              div_ovf;
  logic              step_is_div;
  logic              unused_inst_bits;

  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};
  assign in_ready         = (state == IDLE);
  assign out_valid        = (state == DONE);
  assign step_is_div      = op_is_div(op);

  // Decode of the request as presented; only latched when the request is accepted
  always_comb begin
    dec_op          = md_op_t'(inst[14:12]);
    is_m            = (inst[6:0] == OPCODE_OP) && (inst[31:25] == FUNCT7_MULDIV);
    a_neg           = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && in_a[XLEN-1];
    b_neg           = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && in_b[XLEN-1];
    mag_a           = a_neg ? -in_a : in_a;
    mag_b           = b_neg ? -in_b : in_b;
    div_zero        = op_is_div(dec_op) && (in_b == '0);
    div_ovf         = (dec_op inside {OP_DIV, OP_REM}) && (in_a == MIN_NEG) && (in_b == '1);
    dec_special     = !is_m || div_zero || div_ovf;
    dec_special_val = '0;
    if (is_m && div_zero) begin
      dec_special_val = (dec_op inside {OP_DIV, OP_DIVU}) ? '1 : in_a;
    end else if (is_m && div_ovf) begin
      dec_special_val = (dec_op == OP_DIV) ? in_a : '0;
    end
  end

  // Sign fix-up: quotient and product take sa^sb, remainder follows the dividend
  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                       final_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_val = quo;
      default:                      final_val = rem;
    endcase
    if (special) begin
      final_val = special_val;
    end
  end

  md_step #(.XLEN(XLEN)) u_step (
    .is_div  (step_is_div),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (step_out)
  );

  // Control FSM; the multiplier sits in the low half for MUL*, the dividend for DIV/REM
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      result      <= '0;
      acc         <= '0;
      operand     <= '0;
      op          <= OP_MUL;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op          <= dec_op;
            neg_res     <= a_neg ^ b_neg;
            neg_rem     <= a_neg;
            special     <= dec_special;
            special_val <= dec_special_val;
            count       <= '0;
            state       <= BUSY;
            if (op_is_div(dec_op)) begin
              acc     <= {{XLEN{1'b0}}, mag_a};
              operand <= mag_b;
            end else begin
              acc     <= {{XLEN{1'b0}}, mag_b};
              operand <= mag_a;
            end
          end
        end
        BUSY: begin
          if ((FAST_SPECIAL && special) || (count == STEPS)) begin
            result <= final_val;
            state  <= DONE;
          end else begin
            acc   <= step_out;
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed and randomized checks of alu_md (XLEN=32, FAST_SPECIAL=1) against
// a plain-arithmetic reference of the M-extension rules.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  alu_md #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .inst      (inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] make_inst(input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom;
    r[31:25] = 7'b0000001;
    r[14:12] = f3;
    r[6:0]   = 7'b0110011;
    return r;
  endfunction

  function automatic bit is_m_inst(input logic [31:0] i);
    return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001);
  endfunction

  function automatic bit is_special(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    if (!is_m_inst(i)) return 1'b1;
    if (i[14] && b == 32'h0) return 1'b1;
    if ((i[14:12] == 3'd4 || i[14:12] == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    int          qa;
    int          qb;
    bit          ovf;
    if (!is_m_inst(i)) return 32'h0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    qa  = $signed(a);
    qb  = $signed(b);
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (i[14:12])
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (ovf) return a;
        return qa / qb;
      end
      3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        return qa % qb;
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("ready_wait", 64'(in_ready), 64'd1);
  endtask

  // Presents one request and returns 1ns after its acceptance edge, inputs scrambled
  task automatic apply_stimulus(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    inst     = i;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    inst     = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input int hold);
    int lat = 0;
    out_ready = (hold == 0);
    apply_stimulus(i, a, b);
    check_output({tag, "_busy"}, 64'(out_valid), 64'd0);
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_output({tag, "_res"}, 64'(result), 64'(exp_r));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_output({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_output({tag, "_hold_res"}, 64'(result), 64'(exp_r));
    end
    if (hold > 0) begin
      check_output({tag, "_hs_ready"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_output({tag, "_after_ready"}, 64'(in_ready), 64'd1);
    check_output({tag, "_after_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic watch_quiet(input string tag);
    int seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_output(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] ri;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  f3;

    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    inst      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ready", 64'(in_ready), 64'd1);
    check_output("reset_valid", 64'(out_valid), 64'd0);
    check_output("reset_result", 64'(result), 64'd0);
    rst = 1'b0;

    run_op("mul",     make_inst(3'd0), 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op("mulhu",   make_inst(3'd3), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulh",    make_inst(3'd1), 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulhsu",  make_inst(3'd2), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    run_op("div",     make_inst(3'd4), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op("rem",     make_inst(3'd6), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("divu0",   make_inst(3'd5), 32'd100,      32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("div0",    make_inst(3'd4), 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("remu0",   make_inst(3'd7), 32'h12345678, 32'd0,        32'h12345678, 1, 0);
    run_op("rem_ovf", make_inst(3'd6), 32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 0);
    run_op("div_ovf", make_inst(3'd4), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("non_m",   32'h00A50513,    32'd5,        32'd6,        32'h0,        1, 0);
    run_op("bp",      make_inst(3'd0), 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 5);

    apply_stimulus(make_inst(3'd5), 32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_ready", 64'(in_ready), 64'd1);
    check_output("flush_valid", 64'(out_valid), 64'd0);
    watch_quiet("flush_quiet");

    apply_stimulus(make_inst(3'd0), 32'd3, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("rst_ready", 64'(in_ready), 64'd1);
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_result", 64'(result), 64'd0);
    watch_quiet("rst_quiet");

    inst     = make_inst(3'd0);
    in_a     = 32'd9;
    in_b     = 32'd9;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_output("flush_idle_ready", 64'(in_ready), 64'd1);
    watch_quiet("flush_idle_quiet");

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      ri = make_inst(f3);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      if ($urandom_range(0, 9) == 0) ri[31:25] = 7'b0100000;
      run_op($sformatf("rand%0d", n), ri, ra, rb, ref_result(ri, ra, rb),
             is_special(ri, ra, rb) ? 1 : 33, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter FAST_SPECIAL, default 1; when set, the fast-path cases in REQ-014 complete in one cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the unit accepts a request.
REQ-007 SHALL have port in_a, input, XLEN bits: rs1 operand.
REQ-008 SHALL have port in_b, input, XLEN bits: rs2 operand.
REQ-009 SHALL have port inst, input, 32 bits: the full instruction word; decoded from opcode [6:0], funct7 [31:25] and funct3 [14:12].
REQ-010 SHALL have port flush, input, 1 bit: abort any operation in flight.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port result, output, XLEN bits: the result.

Function
REQ-014 SHALL implement RV M-extension ops on opcode 0110011 with funct7 0000001:
- funct3 000..011 = MUL, MULH, MULHSU, MULHU
- funct3 100..111 = DIV, DIVU, REM, REMU
- any other inst: fast path with result 0
REQ-015 SHALL use FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept a request when in_valid & in_ready at edge T; it captures operands, op and signs.
REQ-017 Normal path: BUSY for exactly XLEN cycles (one radix-2 shift-add or restoring-subtract step per cycle, counter 0..XLEN-1); DONE from edge T+XLEN+1.
REQ-018 Fast path (FAST_SPECIAL=1), DONE at edge T+1, for:
- divide by zero: DIV/DIVU give all-ones; REM/REMU give in_a
- signed overflow (in_a = 2^(XLEN-1), in_b = -1): DIV gives in_a; REM gives 0
- non-M inst
When FAST_SPECIAL=0, the same values are produced after the full normal latency.
REQ-019 Signed ops SHALL iterate on magnitudes, then apply the sign fix-up: the quotient sign is sa^sb, the remainder sign follows the dividend. MULHSU treats in_b as unsigned. MUL returns the low XLEN bits; MULH* return the high XLEN bits of the 2*XLEN-bit product.
REQ-020 In DONE, result and out_valid SHALL hold stable until out_ready; the unit moves to IDLE on the edge where out_valid & out_ready.
REQ-021 The unit SHALL NOT accept a new request in the same cycle as a DONE handshake; in_ready rises the cycle after.
REQ-022 flush SHALL force IDLE on the next edge from any state, discarding the operation, with out_valid low that cycle.
REQ-023 flush and in_valid asserted in the same IDLE cycle: flush wins and the request is not accepted.
REQ-024 Operands and inst SHALL be sampled only at acceptance; input changes during BUSY have no effect.

Reset
REQ-025 While rst is high at an edge, the unit SHALL set state=IDLE, counter=0, result=0 and out_valid=0; in_ready is high in the first cycle after reset releases.
REQ-026 rst during BUSY or DONE SHALL discard the operation; no out_valid pulse follows.
REQ-027 rst SHALL take priority over flush and over handshakes.

Structure
REQ-028 A shared package alu_md_pkg SHALL hold:
- opcode and funct7 constants
- the funct3 op enum (md_op_t)
- the FSM state typedef (md_state_t)
REQ-029 One sub-module, md_step, SHALL implement a single combinational iteration (conditional add or trial subtract plus shift) over 2*XLEN-bit partial state; alu_md instantiates it once.

Verification (XLEN=32)
REQ-030 MUL, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid at T+33.
REQ-031 MULHU, a=b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH, a=0x80000000, b=0x80000000 -> result 0x40000000.
REQ-032 DIV and REM, a=0xFFFFFFF9 (-7), b=2 -> DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFF.
REQ-033 Fast path with FAST_SPECIAL=1:
- DIVU 100/0 -> 0xFFFFFFFF at T+1
- REM 0x80000000 % 0xFFFFFFFF -> 0 at T+1
- DIV of the same operands -> 0x80000000
REQ-034 Backpressure: hold out_ready low for 5 cycles in DONE -> result and out_valid are stable throughout; in_ready is high on the cycle after the handshake.
REQ-035 flush at BUSY cycle 10 -> IDLE next cycle, out_valid is never asserted. rst at BUSY cycle 5 -> same outcome, and result=0.
